// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch engine: FSM states and the
// prefetch FIFO entry that pairs each instruction with its word address.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with flush. The head entry is held in registers so the
// decode stage sees a clean registered valid/data/address; a word pushed
// into an empty FIFO appears at the head on the following cycle.
module fetch_fifo import fetch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output fetch_entry_t     head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             pop_en, push_en;
    fetch_entry_t     head_q, head_d;

    // Next pointers, occupancy and head word; a flush overrides push and pop
    always_comb begin
        pop_en  = pop_i && (count_q != '0) && !flush_i;
        push_en = push_i && ((count_q != CNT_W'(DEPTH)) || pop_en) && !flush_i;
        rd_d    = rd_q + PTR_W'(pop_en);
        wr_d    = wr_q + PTR_W'(push_en);
        count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        valid_d = (count_d != '0);
        head_d  = head_q;
        // When the incoming word becomes the head it is not in storage yet
        if (push_en && (count_q == CNT_W'(pop_en))) begin
            head_d = push_data_i;
        end else if (count_d != '0) begin
            head_d = mem_q[rd_d];
        end
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            valid_d = 1'b0;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    // Pointers, count and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = valid_q;
    assign head_o       = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: issues one RAM word request at a time, stores
// each response with its address in the prefetch FIFO, and handles
// redirects by flushing the FIFO and discarding any in-flight response.
module fetch_unit import fetch_pkg::*; #(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    output logic              en_ram_out,
    output logic [ADDR_W-1:0] addr,
    input  logic              en_ram_in,
    input  logic [DATA_W-1:0] ins,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins_out,
    output logic [ADDR_W-1:0] ins_addr,
    input  logic              ins_ready,
    output logic              resp_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q, addr_q;
    logic              en_ram_out_q, resp_err_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_post;
    logic              push, pop, can_issue;
    fetch_entry_t      push_entry, head;

    assign push_entry = '{addr: pc_q, data: ins};

    // FIFO controls and the issue condition, evaluated on post-push/pop occupancy
    always_comb begin
        push       = (state_q == ST_WAIT) && en_ram_in && !jump;
        pop        = ins_valid && ins_ready && !jump;
        count_post = count + CNT_W'(push) - CNT_W'(pop);
        can_issue  = en_in && (count_post < CNT_W'(DEPTH)) && !jump;
    end

    // Fetch FSM with pc, timeout counter and registered RAM-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            en_ram_out_q <= 1'b0;
            tmo_q        <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            en_ram_out_q <= 1'b0;
            if (en_ram_in && ((state_q == ST_IDLE) || (state_q == ST_REQ))) begin
                resp_err_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (jump) begin
                        pc_q <= jump_addr;
                    end else if (can_issue) begin
                        state_q      <= ST_REQ;
                        en_ram_out_q <= 1'b1;
                        addr_q       <= pc_q;
                    end
                end
                ST_REQ: begin
                    tmo_q <= '0;
                    if (jump) begin
                        pc_q    <= jump_addr;
                        state_q <= ST_DISCARD;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (en_ram_in) begin
                        tmo_q <= '0;
                        if (jump) begin
                            pc_q    <= jump_addr;
                            state_q <= ST_IDLE;
                        end else begin
                            pc_q <= pc_q + ADDR_W'(1);
                            if (can_issue) begin
                                state_q      <= ST_REQ;
                                en_ram_out_q <= 1'b1;
                                addr_q       <= pc_q + ADDR_W'(1);
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end else if (jump) begin
                        pc_q    <= jump_addr;
                        tmo_q   <= '0;
                        state_q <= ST_DISCARD;
                    end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                        // Abandon the request; pc is kept so it is re-requested
                        resp_err_q <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_DISCARD: begin
                    if (jump) begin
                        pc_q <= jump_addr;
                    end
                    if (en_ram_in) begin
                        tmo_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                        resp_err_q <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst),
        .flush_i      (jump),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .count_o      (count),
        .head_valid_o (ins_valid),
        .head_o       (head)
    );

    assign en_ram_out = en_ram_out_q;
    assign addr       = addr_q;
    assign resp_err   = resp_err_q;
    assign ins_out    = head.data;
    assign ins_addr   = head.addr;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Initiator-side instruction fetch engine for the single-word RAM request/response interface (en_ram_out/addr out, ins/en_ram_in back). It lives in the CPU and replaces ad-hoc fetch logic. It issues sequential word requests, captures each returned word with its address into a small prefetch FIFO, and presents a valid/ready instruction stream to the decode stage. It also supports redirect (jump) with discard of any in-flight response.

Parameters:
ADDR_W, 16, address width (word address)
DATA_W, 16, instruction width
DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
RESET_PC, 16'h0000, first fetch address after reset
TIMEOUT, 255, max WAIT cycles before abandoning a request

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
en_in  in  1  fetch enable; 0 = issue no new requests
en_ram_out  out  1  request strobe to RAM, one-cycle pulse
addr  out  ADDR_W  request address, stable from request through response
en_ram_in  in  1  response strobe from RAM, one-cycle pulse
ins  in  DATA_W  response data, valid when en_ram_in=1
jump  in  1  redirect pulse
jump_addr  in  ADDR_W  redirect target, sampled when jump=1
ins_valid  out  1  FIFO non-empty
ins_out  out  DATA_W  head instruction
ins_addr  out  ADDR_W  address of head instruction
ins_ready  in  1  consumer pops head when ins_valid & ins_ready
resp_err  out  1  sticky: spurious response or timeout seen

Behaviour:
- Reset (rst=0, async): state IDLE, pc=RESET_PC, addr=RESET_PC, en_ram_out=0, FIFO empty, ins_valid=0, ins_out=0, ins_addr=0, resp_err=0, timeout counter=0. Reset mid-request abandons the request. A late response after release is spurious.
- At most one request outstanding.
- State IDLE: if en_in & (count < DEPTH) & !jump, go to REQ.
- State REQ (1 cycle): en_ram_out=1, addr=pc, go to WAIT.
- State WAIT: addr holds. On en_ram_in, push {pc, ins}, pc<=pc+1 (wraps FFFF->0000), and clear the counter. Next state is REQ if the IDLE condition holds at that cycle using post-push count, else IDLE. Best-case throughput is one word per (RAM latency + 1) cycles.
- Response to FIFO output latency: response at cycle t gives ins_valid/ins_out at t+1. There is no bypass.
- Redirect (jump=1), any state:
  - FIFO flushed that cycle and pc<=jump_addr.
  - From REQ, or from WAIT without en_ram_in that cycle, go to DISCARD.
  - From WAIT with en_ram_in the same cycle, drop the data and go to IDLE.
  - Jump has priority over a same-cycle pop and push. The pop is ignored and count becomes 0.
- State DISCARD: wait for en_ram_in, drop the data, go to IDLE. A jump here updates pc only and stays in DISCARD.
- Timeout: counter runs in WAIT/DISCARD. When it reaches TIMEOUT, set resp_err and go to IDLE. pc is unchanged, so the same address is re-requested.
- en_ram_in in IDLE/REQ: ignored, resp_err<=1.
- FIFO: simultaneous push and pop leaves count unchanged. Pop when empty is ignored. Push is never attempted when full, because issue is gated by count < DEPTH with one outstanding request. Pointers wrap modulo DEPTH.
- en_in=0 during WAIT: the outstanding response still completes and is stored. No new request is issued.
- resp_err clears only on reset.

Decomposition:
- fetch_pkg: state enum (IDLE, REQ, WAIT, DISCARD), ADDR_W/DATA_W defaults, FIFO entry struct {addr, data}.
- Sub-module fetch_fifo: synchronous FIFO with flush, push/pop/count, and head registered outputs.
- FSM, pc and timeout logic live in fetch_unit.

Test Plan:
- Reset release, en_in=1, RAM model with 2-cycle latency returning ins=addr^16'hA5A5. Required: en_ram_out pulses at addr 0,1,2,3, and the FIFO fills to 4 with ins_ready=0. No 5th request until a pop; the 5th request follows the first pop by one cycle.
- ins_ready=1 continuously, 1-cycle RAM. Required: ins_valid stream with ins_addr 0,1,2…, no gaps or duplicates, one word every 2 cycles.
- jump to 16'h0100 while in WAIT for addr 3. Required: FIFO empties next cycle and the response for 3 is dropped. The next request is 16'h0100, and the first ins_addr out is 0x0100.
- jump on the same cycle as en_ram_in and a pop. Required: data dropped, count=0, next request at jump_addr.
- pc=16'hFFFF fetched. Required: the next request addr is 16'h0000.
- RAM never responds. Required: after TIMEOUT cycles resp_err=1 and addr is re-requested. A stray en_ram_in while IDLE also sets resp_err. A mid-WAIT rst=0 clears all outputs immediately.
